// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing a single i2c_master between NREQ requesters.
// Optional ISSUE/BUSY phase watchdog is enabled by defining I2C_ARB_WATCHDOG_EN.
module i2c_bus_arbiter #(
    parameter int NREQ       = 3,
    parameter int TMO_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*7-1:0]  req_addr,
    input  logic [NREQ*16-1:0] req_din,
    input  logic [NREQ-1:0]    req_rw,
    output logic [NREQ-1:0]    done,
    output logic               err,
    output logic [7:0]         rdata,
    output logic [NREQ-1:0]    grant,
    output logic               m_start,
    output logic [6:0]         m_addr,
    output logic [15:0]        m_din,
    output logic               m_rw,
    input  logic               m_ready,
    input  logic               m_error,
    input  logic [7:0]         m_dout
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || TMO_CYCLES < 1) begin : g_bad_param
        $error("i2c_bus_arbiter: NREQ must be 2..8 and TMO_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] rr_ptr, owner, pick;
    logic          pick_vld;
    logic          wd_tmo;

    // First pending request at or above rr_ptr, wrapping modulo NREQ.
    always_comb begin
        logic [PW:0] idx;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
            if (!pick_vld && req[idx[PW-1:0]]) begin
                pick_vld = 1'b1;
                pick     = idx[PW-1:0];
            end
        end
    end

`ifdef I2C_ARB_WATCHDOG_EN
    localparam int WW = $clog2(TMO_CYCLES + 1);
    logic [WW-1:0] wd_cnt;

    // Restarts on every state change, so each phase gets a fresh budget.
    always_ff @(posedge clk) begin
        if (reset || state_nxt != state)
            wd_cnt <= '0;
        else if (state == ISSUE || state == BUSY)
            wd_cnt <= wd_cnt + 1'b1;
    end

    assign wd_tmo = (state == ISSUE || state == BUSY) && (wd_cnt == WW'(TMO_CYCLES - 1));
`else
    assign wd_tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // A real master response takes priority over a coincident timeout.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (m_ready && pick_vld) state_nxt = ISSUE;
            ISSUE:   if (!m_ready) state_nxt = BUSY;
                     else if (wd_tmo) state_nxt = DONE;
            BUSY:    if (m_ready || wd_tmo) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign done = (state == DONE) ? grant : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr  <= '0;
            owner   <= '0;
            grant   <= '0;
            err     <= 1'b0;
            rdata   <= 8'h00;
            m_start <= 1'b0;
            m_addr  <= 7'h00;
            m_din   <= 16'h0000;
            m_rw    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (m_ready && pick_vld) begin
                        owner   <= pick;
                        grant   <= NREQ'(1) << pick;
                        m_addr  <= req_addr[pick*7 +: 7];
                        m_din   <= req_din[pick*16 +: 16];
                        m_rw    <= req_rw[pick];
                        m_start <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (!m_ready) begin
                        m_start <= 1'b0;
                    end else if (wd_tmo) begin
                        m_start <= 1'b0;
                        err     <= 1'b1;
                        rdata   <= 8'h00;
                    end
                end
                BUSY: begin
                    if (m_ready) begin
                        err   <= m_error;
                        rdata <= m_dout;
                    end else if (wd_tmo) begin
                        err   <= 1'b1;
                        rdata <= 8'h00;
                    end
                end
                DONE: begin
                    grant  <= '0;
                    rr_ptr <= (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares one i2c_master instance between NREQ independent requesters: expander poller, RTC, video-config sequencer.
- Per-requester level request/done-pulse handshake; round-robin grant.
- Drives the master's start/ready protocol: start high until ready falls, then start low until ready rises.
- Returns read data and error to the granted requester. Sits in sys/ between the peripheral drivers and the single SCL/SDA pair.

Parameters:
- NREQ, 3, number of requesters (2..8).
- TMO_CYCLES, 65535, watchdog limit in clk cycles per phase; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  request level per requester.
- req_addr  in  NREQ*7  per-requester 7-bit slave address; requester i uses bits [7i+6:7i].
- req_din  in  NREQ*16  per-requester {register, data} word; requester i uses bits [16i+15:16i].
- req_rw  in  NREQ  per-requester transfer direction: 1 = read, 0 = write.
- done  out  NREQ  one-cycle completion pulse to the granted requester.
- err  out  1  error status; valid in the done cycle.
- rdata  out  8  read byte; valid in the done cycle when the transfer was a read.
- grant  out  NREQ  one-hot current owner; all zero when idle.
- m_start  out  1  to i2c_master start.
- m_addr  out  7  to i2c_master addr.
- m_din  out  16  to i2c_master data_in.
- m_rw  out  1  to i2c_master rw.
- m_ready  in  1  from i2c_master ready.
- m_error  in  1  from i2c_master error.
- m_dout  in  8  from i2c_master data_out.

Behaviour:
- Reset (synchronous, any state, including mid-transfer):
  - state=IDLE, rr_ptr=0.
  - grant=0, done=0, err=0, rdata=0.
  - m_start=0, m_addr=0, m_din=0, m_rw=0.
- State machine: IDLE -> ISSUE -> BUSY -> DONE -> IDLE.
- IDLE:
  - Wait for m_ready=1.
  - If any req bit is set, pick the first set bit scanning from rr_ptr upward with wrap modulo NREQ.
  - Set grant one-hot to that requester.
  - Latch its addr/din/rw into m_addr/m_din/m_rw. These hold stable until the next grant.
  - Set m_start=1 and go to ISSUE. Grant-to-m_start latency is 1 cycle from the req sample.
- ISSUE: hold m_start=1 until m_ready=0, then set m_start=0 and go to BUSY.
- BUSY: when m_ready=1, capture m_error into err and m_dout into rdata, then go to DONE.
- DONE:
  - Assert done[owner]=1 for exactly one cycle; err and rdata are valid in this cycle.
  - Set rr_ptr=owner+1, wrapping to 0 after NREQ-1.
  - Clear grant and return to IDLE.
- Handshake rules:
  - A requester keeps req high and its payload stable until it sees its done pulse.
  - Payload is sampled once, at grant; later changes do not affect the transfer in flight.
  - If req stays high after done, it counts as a new request. Round-robin places it behind all other pending requesters.
  - A req dropped before grant is ignored. A req dropped after grant does not abort the transfer; done still pulses.
- Arbitration:
  - Simultaneous requests are served in rr_ptr order.
  - A single requester can issue back-to-back transfers; minimum gap is 1 idle cycle.
  - No requester waits more than NREQ-1 transfers.
- err and rdata hold their last values outside the done cycle. rdata updates on writes too (master output, don't-care).
- m_ready=0 in IDLE (master still busy after reset) blocks granting.

Optional Feature:
- Macro: I2C_ARB_WATCHDOG_EN.
- With the macro:
  - A counter resets on every entry to ISSUE and BUSY.
  - If it reaches TMO_CYCLES in either state: m_start=0, err=1, rdata=0, go to DONE. Normal done pulse and rr_ptr advance.
  - After a watchdog abort, IDLE still waits for m_ready=1 before the next grant.
- Without the macro: no counter logic; ISSUE and BUSY wait indefinitely.

Test Plan:
- Single write: req[0] with addr=0x20, din=0x0524, rw=0; master model drops ready 2 cycles after start and raises it 40 cycles later. Expect:
  - m_start=1 the cycle after req is sampled, low the cycle after ready=0.
  - done[0] pulses once with err=0.
  - grant=3'b001 during the transfer.
- Read: req[1] with rw=1; master returns m_dout=0xA5, m_error=0 -> done[1] pulse with rdata=0xA5, err=0.
- Contention: req=3'b111 held continuously from reset -> grant order 0,1,2,0,1,2; each done pulse is on the matching bit.
- NACK: master ends the transfer with m_error=1 -> err=1 in the done cycle; the next transfer with m_error=0 gives err=0.
- Reset mid-BUSY: assert reset 10 cycles into BUSY -> next cycle m_start=0, grant=0, done=0. After release, the pending req[2] is granted first (rr_ptr=0 scan, no lower request).
- With I2C_ARB_WATCHDOG_EN, TMO_CYCLES=100, master never drops ready -> m_start falls and done pulses with err=1 after 100 cycles in ISSUE. The next requester is served once ready=1.
